jpeg_stage_sequencer: RTL

Parametrised top-level sequencer for the JPEG encode pipeline. It steps a chain of `NUM_STAGES` processing blocks (RGB→YCbCr, DCT, quantiser, Huffman, …) in order for each 8×8 block of a multi-block frame. It adds block counting, a per-stage watchdog, abort, and a single-cycle frame-done pulse. It replaces the fixed single-block controller and sits between the system front end and the per-stage enable/valid pins.

---
 rtl/jpeg_pkg.sv | 28 ++
 rtl/jpeg_stage_sequencer_watchdog.sv | 44 ++++
 rtl/jpeg_stage_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/jpeg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jpeg_pkg
//  Purpose  : Shared definitions for the JPEG encode pipeline control path:
//             sequencer state encoding, default stage count and the index
//             of each processing stage in the chain.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package jpeg_pkg;

    // Default number of chained processing stages
    localparam int c_DEF_NUM_STAGES = 4;

    // Sequencer state encoding
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;
    localparam logic [1:0] c_ERR  = 2'd3;

    // Position of each processing block in the chain
    localparam int c_STG_RGB2YCBCR = 0;
    localparam int c_STG_DCT       = 1;
    localparam int c_STG_QUAN      = 2;
    localparam int c_STG_HUFF      = 3;

endpackage : jpeg_pkg
`default_nettype wire

// File: rtl/jpeg_stage_sequencer_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : stage_watchdog
//  Purpose  : Per-stage cycle counter. Counts cycles while enabled, clears on
//             request, and flags expiry in the last permitted cycle so the
//             sequencer can leave the stage on the following edge.
//  Ports    : clk, rst_n      - clock, synchronous active-low reset
//             i_clr           - clear counter (stage entry / not running)
//             i_en            - count enable (stage active)
//             i_limit         - cycle limit, 0 disables expiry
//             o_expired       - counter reached i_limit-1 while enabled
//  Revision : 1.0  initial release
// ============================================================================
module stage_watchdog
    import jpeg_pkg::*;
#(
    parameter int TO_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clr,
    input  logic            i_en,
    input  logic [TO_W-1:0] i_limit,
    output logic            o_expired
);

    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + TO_W'(1);
        end
    end

    // Counter value k means the stage is in its (k+1)-th enabled cycle, so
    // matching limit-1 marks the final cycle the stage is allowed.
    assign o_expired = i_en && (i_limit != '0) && (r_cnt == (i_limit - TO_W'(1)));

endmodule : stage_watchdog
`default_nettype wire

// File: rtl/jpeg_stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : jpeg_stage_sequencer
//  Purpose  : Steps a chain of NUM_STAGES processing blocks in order for every
//             8x8 block of a frame, with block counting, per-stage watchdog,
//             abort and a single-cycle frame-done pulse.
//  Ports    : clk, rst_n      - clock, synchronous active-low reset
//             start           - frame start pulse (accepted in IDLE only)
//             num_blocks      - blocks in the frame, captured on start
//             timeout_limit   - per-stage cycle limit (0 = off), captured
//             abort           - return to IDLE from any state
//             stage_done      - per-stage completion, active stage only
//             stage_en        - one-hot enable of the active stage
//             busy            - frame in progress
//             frame_valid     - one-cycle frame completion pulse
//             error           - watchdog expired, waiting for abort/reset
//             cur_stage       - index of the active stage
//             blk_idx         - index of the block in flight
//  Revision : 1.0  initial release
// ============================================================================
module jpeg_stage_sequencer
    import jpeg_pkg::*;
#(
    parameter int NUM_STAGES = c_DEF_NUM_STAGES,
    parameter int BLK_W      = 12,
    parameter int TO_W       = 16,
    parameter int CS_W       = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BLK_W-1:0]      num_blocks,
    input  logic [TO_W-1:0]       timeout_limit,
    input  logic                  abort,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic                  busy,
    output logic                  frame_valid,
    output logic                  error,
    output logic [CS_W-1:0]       cur_stage,
    output logic [BLK_W-1:0]      blk_idx
);

    localparam logic [CS_W-1:0] c_LAST_STAGE = CS_W'(NUM_STAGES - 1);

    logic [1:0]       r_state;
    logic [CS_W-1:0]  r_cur_stage;
    logic [BLK_W-1:0] r_blk_idx;
    logic [BLK_W-1:0] r_num_blocks;
    logic [TO_W-1:0]  r_limit;

    logic w_run;
    logic w_done;
    logic w_last_stage;
    logic w_last_blk;
    logic w_expired;

    assign w_run        = (r_state == c_RUN);
    // Only the active stage's completion bit is looked at
    assign w_done       = w_run && stage_done[r_cur_stage];
    assign w_last_stage = (r_cur_stage == c_LAST_STAGE);
    // num_blocks is non-zero whenever RUN is entered, so minus one never wraps
    assign w_last_blk   = (r_blk_idx == (r_num_blocks - BLK_W'(1)));

    // Cleared outside RUN and on every handoff so each stage starts at zero
    stage_watchdog #(
        .TO_W (TO_W)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (!w_run || w_done),
        .i_en      (w_run),
        .i_limit   (r_limit),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_cur_stage  <= '0;
            r_blk_idx    <= '0;
            r_num_blocks <= '0;
            r_limit      <= '0;
        end else if (abort) begin
            r_state     <= c_IDLE;
            r_cur_stage <= '0;
            r_blk_idx   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_num_blocks <= num_blocks;
                        r_limit      <= timeout_limit;
                        r_cur_stage  <= '0;
                        r_blk_idx    <= '0;
                        r_state      <= (num_blocks != '0) ? c_RUN : c_DONE;
                    end
                end
                c_RUN: begin
                    // Completion in the expiry cycle takes precedence
                    if (w_done) begin
                        if (!w_last_stage) begin
                            r_cur_stage <= r_cur_stage + CS_W'(1);
                        end else if (!w_last_blk) begin
                            r_cur_stage <= '0;
                            r_blk_idx   <= r_blk_idx + BLK_W'(1);
                        end else begin
                            r_state <= c_DONE;
                        end
                    end else if (w_expired) begin
                        r_state <= c_ERR;
                    end
                end
                c_DONE: begin
                    r_state     <= c_IDLE;
                    r_cur_stage <= '0;
                    r_blk_idx   <= '0;
                end
                default: begin
                    // ERR: position held for debug until abort or reset
                    r_state <= c_ERR;
                end
            endcase
        end
    end

    always_comb begin
        stage_en = '0;
        if (w_run) begin
            stage_en[r_cur_stage] = 1'b1;
        end
    end

    assign busy        = w_run;
    assign frame_valid = (r_state == c_DONE);
    assign error       = (r_state == c_ERR);
    assign cur_stage   = r_cur_stage;
    assign blk_idx     = r_blk_idx;

endmodule : jpeg_stage_sequencer
`default_nettype wire
